// File: rtl/chunked_add_sub_if.sv
// rtl/chunked_add_sub_if.sv - request/result handshake bundle for the chunked add/sub unit
interface chunked_add_sub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, op, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, zero, acc
  );

  modport slave (
    input  in_valid, op, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, overflow, zero, acc
  );
endinterface

// File: rtl/chunked_add_sub.sv
// rtl/chunked_add_sub.sv - multi-cycle add/subtract/accumulate unit working CHUNK bits per clock
module chunked_add_sub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clock,
  input  logic             resetn,
  chunked_add_sub_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] acc_r;
  logic             carry;
  logic             is_acc;
  logic             cout_r;
  logic             ovf_r;
  logic             zero_r;
  logic [IDX_W-1:0] idx;

  logic [CHUNK:0]   chunk_res;
  logic             msb_carry_in;
  logic [WIDTH-1:0] next_sum;

  // Operands shift right one chunk per cycle, so the chunk being added is always the low one;
  // result chunks enter the sum from the top and land in place after NCHUNK shifts.
  always_comb begin
    chunk_res    = {1'b0, op_a[CHUNK-1:0]} + {1'b0, op_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
    msb_carry_in = op_a[CHUNK-1] ^ op_b[CHUNK-1] ^ chunk_res[CHUNK-1];
    next_sum     = (sum_r >> CHUNK) | (WIDTH'(chunk_res[CHUNK-1:0]) << (WIDTH - CHUNK));
  end

  // Control FSM plus datapath registers; results and flags are held until the next completion
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      op_a   <= '0;
      op_b   <= '0;
      sum_r  <= '0;
      acc_r  <= '0;
      carry  <= 1'b0;
      is_acc <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
      idx    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            if (bus.op == OP_CLR) begin
              sum_r  <= '0;
              cout_r <= 1'b0;
              ovf_r  <= 1'b0;
              zero_r <= 1'b1;
              acc_r  <= '0;
              state  <= S_DONE;
            end else begin
              op_a   <= (bus.op == OP_ACC) ? acc_r : bus.a;
              op_b   <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
              carry  <= (bus.op == OP_SUB) ? 1'b1 : bus.cin;
              is_acc <= (bus.op == OP_ACC);
              idx    <= '0;
              state  <= S_RUN;
            end
          end
        end
        S_RUN: begin
          op_a  <= op_a >> CHUNK;
          op_b  <= op_b >> CHUNK;
          sum_r <= next_sum;
          carry <= chunk_res[CHUNK];
          idx   <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            cout_r <= chunk_res[CHUNK];
            ovf_r  <= msb_carry_in ^ chunk_res[CHUNK];
            zero_r <= (next_sum == '0);
            if (is_acc) begin
              acc_r <= next_sum;
            end
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.overflow  = ovf_r;
  assign bus.zero      = zero_r;
  assign bus.acc       = acc_r;
endmodule

// File: tb/tb_chunked_add_sub.sv
// tb/tb_chunked_add_sub.sv - scoreboard bench for chunked_add_sub against an arithmetic reference
module tb_chunked_add_sub;
  localparam int W = 16;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, CLR = 2'b11;

  logic clock = 1'b0;
  logic resetn;
  logic resetn2;

  always #5 clock = ~clock;

  chunked_add_sub_if #(.WIDTH(W)) i1 ();
  chunked_add_sub_if #(.WIDTH(W)) i2 ();

  chunked_add_sub #(.WIDTH(W), .CHUNK(4))  dut   (.clock(clock), .resetn(resetn),  .bus(i1));
  chunked_add_sub #(.WIDTH(W), .CHUNK(16)) dut16 (.clock(clock), .resetn(resetn2), .bus(i2));

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [15:0] acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] model_acc;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the whole operands
  task automatic push_expect(input logic [1:0] o, input logic [15:0] av, input logic [15:0] bv,
                             input logic c);
    exp_t        e;
    logic [15:0] x;
    int          r;
    int          sr;
    if (o == CLR) begin
      model_acc = 16'h0;
      e.sum = 16'h0; e.cout = 1'b0; e.ovf = 1'b0; e.zero = 1'b1; e.acc = 16'h0;
    end else begin
      if (o == SUB) begin
        r      = int'(av) - int'(bv);
        sr     = int'($signed(av)) - int'($signed(bv));
        e.cout = (r >= 0);
      end else begin
        x      = (o == ACC) ? model_acc : av;
        r      = int'(x) + int'(bv) + int'(c);
        sr     = int'($signed(x)) + int'($signed(bv)) + int'(c);
        e.cout = (r > 65535);
      end
      e.sum  = 16'(r);
      e.ovf  = (sr > 32767) || (sr < -32768);
      e.zero = (e.sum == 16'h0);
      if (o == ACC) model_acc = e.sum;
      e.acc = model_acc;
    end
    sb.push_back(e);
  endtask

  // Monitor: every result the consumer takes is compared with the oldest expectation
  always @(negedge clock) begin
    if (resetn && i1.out_valid && i1.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("sum",      i1.sum,      mon_e.sum);
        chk("cout",     i1.cout,     mon_e.cout);
        chk("overflow", i1.overflow, mon_e.ovf);
        chk("zero",     i1.zero,     mon_e.zero);
        chk("acc",      i1.acc,      mon_e.acc);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [15:0] av, input logic [15:0] bv,
                       input logic c);
    int n;
    int lat;
    n = 0;
    @(negedge clock);
    while (!i1.in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("in_ready_before_issue", i1.in_ready, 1);
    i1.in_valid = 1'b1; i1.op = o; i1.a = av; i1.b = bv; i1.cin = c;
    push_expect(o, av, bv, c);
    @(posedge clock); #1;
    i1.in_valid = 1'b0;
    i1.op = 2'($urandom); i1.a = 16'($urandom); i1.b = 16'($urandom); i1.cin = 1'($urandom);
    lat = 0;
    while (!i1.out_valid && lat < 50) begin
      @(posedge clock); #1;
      lat++;
    end
    chk("latency", lat, (o == CLR) ? 0 : 4);
  endtask

  task automatic wait_ready2();
    int n;
    n = 0;
    @(negedge clock);
    while (!i2.in_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("c16_in_ready", i2.in_ready, 1);
  endtask

  logic [15:0] held_sum;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; resetn2 = 1'b0; model_acc = 16'h0;
    i1.in_valid = 1'b0; i1.op = ADD; i1.a = '0; i1.b = '0; i1.cin = 1'b0; i1.out_ready = 1'b1;
    i2.in_valid = 1'b0; i2.op = ADD; i2.a = '0; i2.b = '0; i2.cin = 1'b0; i2.out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_in_ready",  i1.in_ready,  1);
    chk("rst_out_valid", i1.out_valid, 0);
    chk("rst_sum",       i1.sum,       0);
    chk("rst_cout",      i1.cout,      0);
    chk("rst_overflow",  i1.overflow,  0);
    chk("rst_zero",      i1.zero,      0);
    chk("rst_acc",       i1.acc,       0);
    resetn = 1'b1; resetn2 = 1'b1;

    issue(ADD, 16'h1234, 16'h0FF1, 1'b0);
    issue(SUB, 16'h0005, 16'h0007, 1'b0);
    issue(ADD, 16'h7FFF, 16'h0001, 1'b0);
    issue(ADD, 16'hFFFF, 16'h0001, 1'b0);
    issue(SUB, 16'h8000, 16'h0001, 1'b0);

    // consumer stall: results frozen, new requests refused
    @(posedge clock); #1;
    i1.out_ready = 1'b0;
    issue(ADD, 16'h00A5, 16'h0F0F, 1'b1);
    held_sum = i1.sum;
    i1.in_valid = 1'b1; i1.op = ADD; i1.a = 16'h1111; i1.b = 16'h2222;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("stall_out_valid", i1.out_valid, 1);
      chk("stall_in_ready",  i1.in_ready,  0);
      chk("stall_sum",       i1.sum,       held_sum);
    end
    i1.in_valid = 1'b0;
    @(posedge clock); #1;
    i1.out_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("release_out_valid", i1.out_valid, 0);
    chk("release_in_ready",  i1.in_ready,  1);

    // accumulator chain
    issue(CLR, 16'hDEAD, 16'hBEEF, 1'b1);
    issue(ACC, 16'hFFFF, 16'h0003, 1'b0);
    issue(ACC, 16'h1234, 16'h0004, 1'b0);
    issue(ACC, 16'h0000, 16'h0005, 1'b0);
    issue(ADD, 16'h0001, 16'h0001, 1'b0);
    chk("acc_kept_by_add", i1.acc, 16'h000C);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      logic [1:0] o;
      o = ($urandom_range(0, 9) == 0) ? CLR : 2'($urandom_range(0, 2));
      issue(o, 16'($urandom), 16'($urandom), 1'($urandom));
    end

    // reset while RUN
    issue(CLR, 16'h0, 16'h0, 1'b0);
    issue(ACC, 16'h0, 16'h0100, 1'b0);
    @(negedge clock);
    while (!i1.in_ready) @(negedge clock);
    i1.in_valid = 1'b1; i1.op = ADD; i1.a = 16'h1111; i1.b = 16'h2222; i1.cin = 1'b0;
    @(posedge clock); #1;
    i1.in_valid = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b0;
    #1;
    chk("midrun_rst_out_valid", i1.out_valid, 0);
    chk("midrun_rst_in_ready",  i1.in_ready,  1);
    chk("midrun_rst_acc",       i1.acc,       0);
    sb.delete();
    model_acc = 16'h0;
    #2 resetn = 1'b1;
    issue(ADD, 16'h0002, 16'h0002, 1'b0);

    // single-chunk instance
    wait_ready2();
    i2.in_valid = 1'b1; i2.op = ADD; i2.a = 16'h7FFF; i2.b = 16'h0001; i2.cin = 1'b0;
    @(posedge clock); #1;
    i2.in_valid = 1'b0;
    chk("c16_run_out_valid", i2.out_valid, 0);
    @(posedge clock); #1;
    chk("c16_out_valid", i2.out_valid, 1);
    chk("c16_sum",       i2.sum,       16'h8000);
    chk("c16_overflow",  i2.overflow,  1);
    chk("c16_cout",      i2.cout,      0);
    wait_ready2();
    i2.in_valid = 1'b1; i2.op = ACC; i2.a = 16'hAAAA; i2.b = 16'h0009; i2.cin = 1'b1;
    @(posedge clock); #1;
    i2.in_valid = 1'b0;
    @(posedge clock); #1;
    chk("c16_acc_sum", i2.sum, 16'h000A);
    chk("c16_acc",     i2.acc, 16'h000A);
    wait_ready2();
    i2.in_valid = 1'b1; i2.op = ADD; i2.a = 16'h1234; i2.b = 16'h0001; i2.cin = 1'b0;
    @(posedge clock); #1;
    i2.in_valid = 1'b0;
    resetn2 = 1'b0;
    #1;
    chk("c16_rst_out_valid", i2.out_valid, 0);
    chk("c16_rst_in_ready",  i2.in_ready,  1);
    chk("c16_rst_acc",       i2.acc,       0);
    #2 resetn2 = 1'b1;
    wait_ready2();
    i2.in_valid = 1'b1; i2.op = ADD; i2.a = 16'h0002; i2.b = 16'h0002; i2.cin = 1'b0;
    @(posedge clock); #1;
    i2.in_valid = 1'b0;
    @(posedge clock); #1;
    chk("c16_post_rst_valid", i2.out_valid, 1);
    chk("c16_post_rst_sum",   i2.sum,       16'h0004);

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
